// File: rtl/pci_target_burst.sv
// PCI target data-phase engine: decodes the address phase, claims memory
// read/write hits in its window and runs bursts against a local word store.
module pci_target_burst #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 3,
  parameter logic [DATA_W-1:0] BASE_ADDR   = DATA_W'(32'h0000_1000),
  parameter int                WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Frame,
  input  logic                Irdy,
  input  logic [DATA_W/8-1:0] Cbe,
  input  logic [DATA_W-1:0]   AD_in,
  output logic [DATA_W-1:0]   AD_out,
  output logic                AD_oe,
  output logic                Devsel,
  output logic                Trdy,
  output logic                Stop,
  output logic [1:0]          Phase
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam int              NBYTES   = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [3:0]      WS_LAST  = 4'(WAIT_STATES - 1);
  localparam logic [3:0]      CMD_RD   = 4'b0110;
  localparam logic [3:0]      CMD_WR   = 4'b0111;

  typedef enum logic [2:0] {IDLE, IGNORE, WAIT, XFER, STOPW, TURN} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                isWrite_q;
  logic [3:0]          cnt_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   adOut_q;
  logic                adOe_q;
  logic                devsel_q;
  logic                trdy_q;
  logic                stop_q;
  logic [1:0]          phase_q;

  logic [ADDR_W-1:0]   addrIdx_d;
  logic [ADDR_W-1:0]   idxNext_d;
  logic                hit_d;
  logic [DATA_W-1:0]   wrWord_d;

  assign addrIdx_d = AD_in[ADDR_W+1:2];
  assign idxNext_d = idx_q + 1'b1;
  assign hit_d     = ((Cbe[3:0] == CMD_RD) || (Cbe[3:0] == CMD_WR)) &&
                     (AD_in[DATA_W-1:ADDR_W+2] == BASE_ADDR[DATA_W-1:ADDR_W+2]);

  // Byte-enable merge of the incoming write data over the addressed word.
  always_comb begin
    wrWord_d = mem_q[idx_q];
    for (int i = 0; i < NBYTES; i++) begin
      if (!Cbe[i]) wrWord_d[8*i +: 8] = AD_in[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      isWrite_q <= 1'b0;
      cnt_q     <= '0;
      adOut_q   <= '0;
      adOe_q    <= 1'b0;
      devsel_q  <= 1'b1;
      trdy_q    <= 1'b1;
      stop_q    <= 1'b1;
      phase_q   <= 2'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!Frame) begin
            idx_q     <= addrIdx_d;
            isWrite_q <= Cbe[0];
            cnt_q     <= '0;
            if (hit_d) begin
              devsel_q <= 1'b0;
              phase_q  <= Cbe[0] ? 2'd2 : 2'd1;
              adOe_q   <= !Cbe[0];
              if (WAIT_STATES == 0) begin
                state_q <= XFER;
                trdy_q  <= 1'b0;
                stop_q  <= (addrIdx_d != LAST_IDX);
                adOut_q <= mem_q[addrIdx_d];
              end else begin
                state_q <= WAIT;
              end
            end else begin
              state_q <= IGNORE;
            end
          end
        end
        IGNORE: begin
          if (Frame && Irdy) state_q <= IDLE;
        end
        WAIT: begin
          if (cnt_q == WS_LAST) begin
            state_q <= XFER;
            trdy_q  <= 1'b0;
            stop_q  <= (idx_q != LAST_IDX);
            adOut_q <= mem_q[idx_q];
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        XFER: begin
          if (!Irdy) begin
            if (isWrite_q) mem_q[idx_q] <= wrWord_d;
            // The last word with Frame still low is a disconnect-with-data.
            if (idx_q == LAST_IDX && !Frame) begin
              state_q <= STOPW;
              trdy_q  <= 1'b1;
              stop_q  <= 1'b0;
            end else if (idx_q == LAST_IDX || Frame) begin
              state_q  <= TURN;
              devsel_q <= 1'b1;
              trdy_q   <= 1'b1;
              stop_q   <= 1'b1;
              adOe_q   <= 1'b0;
              phase_q  <= 2'd0;
            end else begin
              idx_q   <= idxNext_d;
              adOut_q <= mem_q[idxNext_d];
              stop_q  <= (idxNext_d != LAST_IDX);
            end
          end
        end
        STOPW: begin
          if (Frame) begin
            state_q  <= TURN;
            devsel_q <= 1'b1;
            trdy_q   <= 1'b1;
            stop_q   <= 1'b1;
            adOe_q   <= 1'b0;
            phase_q  <= 2'd0;
          end
        end
        TURN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign AD_out = adOut_q;
  assign AD_oe  = adOe_q;
  assign Devsel = devsel_q;
  assign Trdy   = trdy_q;
  assign Stop   = stop_q;
  assign Phase  = phase_q;

endmodule

// File: tb/tb_pci_target_burst.sv
// Directed bench for pci_target_burst: one instance with no wait states and
// one with two, sharing stimulus through a selector, checked by a scoreboard.
module tb_pci_target_burst;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        holdA;
  logic        holdB;
  logic        sel;
  logic        frame;
  logic        irdy;
  logic [3:0]  cbe;
  logic [31:0] adIn;

  logic        frameA, irdyA, rstA, frameB, irdyB, rstB;
  logic [31:0] adOutA, adOutB;
  logic        adOeA, devselA, trdyA, stopA;
  logic        adOeB, devselB, trdyB, stopB;
  logic [1:0]  phaseA, phaseB;

  logic [31:0] adOut;
  logic        adOe, devsel, trdy, stop;
  logic [1:0]  phase;

  logic [31:0] model [2][8];
  logic [31:0] expQ [$];
  logic [31:0] wData [8];
  logic [3:0]  wCbe [8];
  int          checks;
  int          failures;
  bit          disc;

  assign frameA = sel ? 1'b1 : frame;
  assign irdyA  = sel ? 1'b1 : irdy;
  assign frameB = sel ? frame : 1'b1;
  assign irdyB  = sel ? irdy : 1'b1;
  assign rstA   = rst_n | holdA;
  assign rstB   = rst_n | holdB;

  assign adOut  = sel ? adOutB  : adOutA;
  assign adOe   = sel ? adOeB   : adOeA;
  assign devsel = sel ? devselB : devselA;
  assign trdy   = sel ? trdyB   : trdyA;
  assign stop   = sel ? stopB   : stopA;
  assign phase  = sel ? phaseB  : phaseA;

  pci_target_burst #(.WAIT_STATES(0)) dutA (
    .clk(clk), .rst_n(rstA), .Frame(frameA), .Irdy(irdyA), .Cbe(cbe), .AD_in(adIn),
    .AD_out(adOutA), .AD_oe(adOeA), .Devsel(devselA), .Trdy(trdyA), .Stop(stopA),
    .Phase(phaseA)
  );

  pci_target_burst #(.WAIT_STATES(2)) dutB (
    .clk(clk), .rst_n(rstB), .Frame(frameB), .Irdy(irdyB), .Cbe(cbe), .AD_in(adIn),
    .AD_out(adOutB), .AD_oe(adOeB), .Devsel(devselB), .Trdy(trdyB), .Stop(stopB),
    .Phase(phaseB)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change mid-cycle; outputs read right after belong to the same bus cycle.
  task automatic applyStimulus(input logic f, input logic ir, input logic [3:0] c,
                               input logic [31:0] d);
    @(negedge clk);
    frame = f;
    irdy  = ir;
    cbe   = c;
    adIn  = d;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_devsel"}, 32'(devsel), 32'd1);
    checkOutput({tag, "_trdy"},   32'(trdy),   32'd1);
    checkOutput({tag, "_stop"},   32'(stop),   32'd1);
    checkOutput({tag, "_adoe"},   32'(adOe),   32'd0);
    checkOutput({tag, "_phase"},  32'(phase),  32'd0);
  endtask

  task automatic runBurst(input bit rd, input logic [31:0] addr, input int n, input int ws,
                          input int stallAt, input int stallLen, output bit discOut);
    int   idx, cyc, stalls, waitCnt;
    bit   cmpl;
    logic irN, expTrdy;
    discOut = 1'b0;
    idx     = int'(addr[4:2]);
    cyc     = 0;
    applyStimulus(1'b0, 1'b1, rd ? 4'h6 : 4'h7, addr);
    for (int w = 0; w < n; w++) begin
      if (rd) expQ.push_back(model[sel][idx]);
      stalls  = 0;
      waitCnt = 0;
      cmpl    = 1'b0;
      while (!cmpl) begin
        cyc++;
        waitCnt++;
        irN = (w == stallAt && stalls < stallLen);
        if (irN) stalls++;
        applyStimulus((w == n - 1), irN, rd ? 4'h0 : wCbe[w], rd ? 32'h0 : wData[w]);
        expTrdy = (cyc >= 1 + ws) ? 1'b0 : 1'b1;
        checkOutput("burst_devsel", 32'(devsel), 32'd0);
        checkOutput("burst_trdy",   32'(trdy),   32'(expTrdy));
        checkOutput("burst_phase",  32'(phase),  rd ? 32'd1 : 32'd2);
        checkOutput("burst_adoe",   32'(adOe),   32'(rd));
        checkOutput("burst_stop",   32'(stop),   (!expTrdy && idx == 7) ? 32'd0 : 32'd1);
        if (rd && !expTrdy && irN) checkOutput("stall_adout", adOut, expQ[0]);
        if (!expTrdy && !irN) begin
          cmpl = 1'b1;
          if (rd) checkOutput("rdata", adOut, expQ.pop_front());
          else begin
            for (int b = 0; b < 4; b++)
              if (!wCbe[w][b]) model[sel][idx][8*b +: 8] = wData[w][8*b +: 8];
          end
        end else if (waitCnt > 20) begin
          checkOutput("trdy_timeout", 32'(waitCnt), 32'd20);
          expQ.delete();
          return;
        end
      end
      if (idx == 7 && w != n - 1) begin
        discOut = 1'b1;
        return;
      end
      idx++;
    end
    applyStimulus(1'b1, 1'b1, 4'h0, 32'h0);
    checkIdle("turn");
    applyStimulus(1'b1, 1'b1, 4'h0, 32'h0);
  endtask

  task automatic missSeq(input logic [3:0] cmd, input logic [31:0] addr);
    applyStimulus(1'b0, 1'b1, cmd, addr);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'hFFFF_FFFF);
    checkIdle("miss_d1");
    applyStimulus(1'b0, 1'b0, 4'h0, 32'hFFFF_FFFF);
    checkIdle("miss_d2");
    applyStimulus(1'b1, 1'b0, 4'h0, 32'hFFFF_FFFF);
    checkIdle("miss_d3");
    applyStimulus(1'b1, 1'b1, 4'h0, 32'h0);
    checkIdle("miss_end");
    applyStimulus(1'b1, 1'b1, 4'h0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    sel      = 1'b0;
    holdA    = 1'b0;
    holdB    = 1'b0;
    rst_n    = 1'b0;
    frame    = 1'b1;
    irdy     = 1'b1;
    cbe      = 4'h0;
    adIn     = 32'h0;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) model[d][i] = 32'h0;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b1, 4'h0, 32'h0);
    applyStimulus(1'b1, 1'b1, 4'h0, 32'h0);
    checkIdle("resetA");
    checkOutput("resetA_adout", adOut, 32'h0);
    sel = 1'b1;
    #1;
    checkIdle("resetB");
    checkOutput("resetB_adout", adOut, 32'h0);
    sel   = 1'b0;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'h0, 32'h0);

    $display("[TB] single write and read at index 2");
    wData[0] = 32'hA5A5_0001;
    wCbe[0]  = 4'h0;
    runBurst(1'b0, 32'h0000_1008, 1, 0, -1, 0, disc);
    runBurst(1'b1, 32'h0000_1008, 1, 0, -1, 0, disc);

    $display("[TB] byte-enabled write burst");
    wData[0] = 32'h1111_1111; wCbe[0] = 4'b0000;
    wData[1] = 32'h2222_2222; wCbe[1] = 4'b1100;
    wData[2] = 32'h3333_3333; wCbe[2] = 4'b0000;
    runBurst(1'b0, 32'h0000_1000, 3, 0, -1, 0, disc);
    runBurst(1'b1, 32'h0000_1000, 3, 0, -1, 0, disc);
    checkOutput("be_model_word1", model[0][1], 32'h0000_2222);

    $display("[TB] read burst with initiator wait");
    runBurst(1'b1, 32'h0000_1000, 3, 0, 1, 2, disc);

    $display("[TB] disconnect at end of window");
    for (int i = 0; i < 4; i++) begin
      wData[i] = 32'hC0DE_0000 + 32'(i);
      wCbe[i]  = 4'h0;
    end
    runBurst(1'b0, 32'h0000_1018, 4, 0, -1, 0, disc);
    checkOutput("disc_flag", 32'(disc), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus((i == 2), 1'b1, 4'h0, 32'h0);
      checkOutput("stopw_trdy",   32'(trdy),   32'd1);
      checkOutput("stopw_stop",   32'(stop),   32'd0);
      checkOutput("stopw_devsel", 32'(devsel), 32'd0);
    end
    applyStimulus(1'b1, 1'b1, 4'h0, 32'h0);
    checkIdle("stopw_turn");
    applyStimulus(1'b1, 1'b1, 4'h0, 32'h0);

    $display("[TB] address miss and bad command");
    missSeq(4'h7, 32'h0000_2000);
    missSeq(4'h2, 32'h0000_1000);

    $display("[TB] full window readback");
    runBurst(1'b1, 32'h0000_1000, 8, 0, -1, 0, disc);

    $display("[TB] wait states and reset mid-burst");
    sel   = 1'b1;
    holdA = 1'b1;
    wData[0] = 32'hDEAD_BEEF;
    wCbe[0]  = 4'h0;
    runBurst(1'b0, 32'h0000_1004, 1, 2, -1, 0, disc);
    runBurst(1'b1, 32'h0000_1004, 1, 2, -1, 0, disc);
    applyStimulus(1'b0, 1'b1, 4'h6, 32'h0000_1004);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0);
    checkOutput("ws_c1_devsel", 32'(devsel), 32'd0);
    checkOutput("ws_c1_trdy",   32'(trdy),   32'd1);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0);
    checkOutput("ws_c2_trdy",   32'(trdy),   32'd1);
    applyStimulus(1'b0, 1'b0, 4'h0, 32'h0);
    checkOutput("ws_c3_trdy",   32'(trdy),   32'd0);
    checkOutput("ws_c3_adout",  adOut,       32'hDEAD_BEEF);
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 4'h0, 32'h0);
    checkIdle("midreset");
    checkOutput("midreset_adout", adOut, 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) model[1][i] = 32'h0;
    applyStimulus(1'b1, 1'b1, 4'h0, 32'h0);
    runBurst(1'b1, 32'h0000_1004, 2, 2, -1, 0, disc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pci_target_burst.md
Name: pci_target_burst

Overview:
- PCI target data-phase engine with a parametrised word store (DEPTH x DATA_W).
- Decodes the address phase and claims memory read/write commands that hit its window.
- Runs multi-word bursts with initiator (Irdy) and target (Trdy) wait states, byte enables, address auto-increment, and disconnect-with-data at the end of the window.
- Sits behind the bus pads as the slave-side transaction controller. Phase reports the active transaction using the existing 0 = none / 1 = read / 2 = write encoding.

Parameters:
- DATA_W, 32, AD width in bits. Must be a multiple of 8 and at least ADDR_W+3.
- ADDR_W, 3, word-index width; DEPTH = 2**ADDR_W.
- BASE_ADDR, 32'h0000_1000, window base. Bits [DATA_W-1:ADDR_W+2] are compared.
- WAIT_STATES, 0, extra cycles between Devsel assertion and first Trdy assertion (0..15).

Ports:
- clk  in  1  rising-edge clock; all state and outputs are registered on it.
- rst_n  in  1  synchronous active-low reset.
- Frame  in  1  active-low transaction framing.
- Irdy  in  1  active-low initiator ready.
- Cbe  in  DATA_W/8  command in the address phase (low 4 bits); active-low byte enables in data phases.
- AD_in  in  DATA_W  address in the address phase; write data in data phases.
- AD_out  out  DATA_W  read data.
- AD_oe  out  1  high while AD_out must drive the bus.
- Devsel  out  1  active-low device select.
- Trdy  out  1  active-low target ready.
- Stop  out  1  active-low stop / disconnect.
- Phase  out  2  0 idle, 1 read active, 2 write active. Value 3 is never driven.

Behaviour:
- Reset (rst_n == 0 at an edge):
  - State goes to IDLE; Devsel, Trdy and Stop go to 1; AD_oe = 0; AD_out = 0; Phase = 0.
  - All memory words clear to 0.
  - Reset wins over any other event, mid-burst included.
- States: IDLE, IGNORE, WAIT, XFER, STOPW, TURN.
- IDLE, edge with Frame == 0 (address phase):
  - Latch command Cbe[3:0] and index idx = AD_in[ADDR_W+1:2].
  - Hit condition: the command is 4'b0110 (read) or 4'b0111 (write), AND AD_in[DATA_W-1:ADDR_W+2] equals the matching BASE_ADDR bits.
  - On a hit: Devsel goes to 0 and Phase goes to 1 or 2. Go to XFER (Trdy = 0) if WAIT_STATES == 0, else go to WAIT.
  - On a miss: go to IGNORE; outputs stay idle.
- IGNORE: return to IDLE on the edge where Frame == 1 and Irdy == 1.
- WAIT:
  - Count WAIT_STATES cycles, then assert Trdy on entry to XFER.
  - Devsel becomes 0 exactly 1 cycle after the address phase; Trdy becomes 0 exactly 1 + WAIT_STATES cycles after it.
- Read data path:
  - AD_oe = 1 from Devsel assertion until TURN.
  - AD_out is loaded with mem[idx] on entry to XFER and after every completed phase.
- Completed phase: an edge where Irdy == 0 and Trdy == 0.
  - Write: for each byte i with Cbe[i] == 0, mem[idx] byte i is loaded from AD_in.
  - Both directions: idx increments by 1.
  - While Irdy == 1, nothing changes (initiator wait).
- Disconnect:
  - While in XFER with idx == DEPTH-1, Stop = 0 together with Trdy = 0 (disconnect with data).
  - idx never wraps. After the last word completes with Frame still 0, go to STOPW: Trdy = 1, Stop = 0, Devsel = 0. Hold until Frame == 1, then go to TURN.
- Normal end:
  - A phase that completes with Frame == 1 goes to TURN.
  - If Frame == 1 while Irdy == 1, keep waiting for Irdy.
- TURN:
  - For one cycle, drive Devsel, Trdy and Stop to 1, AD_oe = 0, Phase = 0.
  - Then go to IDLE. A new Frame == 0 in TURN is ignored; a new address phase is accepted from IDLE only.
- A burst starting at idx k transfers at most DEPTH-k words.

Test Plan:
- Single read: write mem[2] = 32'hA5A5_0001, then read address 32'h0000_1008 with Frame high in the data phase, WAIT_STATES = 0 -> Devsel and Trdy low 1 cycle after the address phase; AD_out = A5A5_0001 on the completed phase; TURN; Phase returns to 0.
- Byte-enabled write burst: write at 32'h0000_1000, 3 words, with Cbe = 4'b0000, 4'b1100, 4'b0000 and data 11111111, 22222222, 33333333 -> readback gives 11111111, 00002222, 33333333.
- Initiator wait: read burst with Irdy high for 2 cycles mid-burst -> AD_out and idx are unchanged during the stall; the next word follows the stall.
- Disconnect: write burst at index 6 while Frame stays low for 4 phases, DEPTH = 8 -> Stop = 0 with the 2nd word; STOPW holds Trdy = 1 until Frame rises; only mem[6..7] are written.
- Miss and bad command: address 32'h0000_2000, then command 4'b0010 at 32'h0000_1000 -> Devsel stays 1 and memory is unchanged in both cases.
- Reset mid-burst with WAIT_STATES = 2: rst_n low during XFER -> all outputs idle on the next edge; memory = 0; Trdy first asserts 3 cycles after the next address phase.
